// File: rtl/uart_rx_if.sv
// uart_rx_if: control inputs and receive-side results of the UART receiver,
// grouped so a host/driver (master) and the receiver (slave) connect as one bundle.
interface uart_rx_if;
  logic       uart_en;
  logic [2:0] baud_rx_sel;
  logic       RX;
  logic       rec_valid;
  logic [7:0] rec_data;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output uart_en, baud_rx_sel, RX,
    input  rec_valid, rec_data, frame_err, rx_busy
  );

  modport slave (
    input  uart_en, baud_rx_sel, RX,
    output rec_valid, rec_data, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first. The RX line is synchronised by two
// flops and sampled mid-bit using a clock-count timer (no oversampling).
// Bit period is BIT_CYC_BASE << (7 - baud_rx_sel) clocks, captured at the
// start of each frame so a mid-frame change of the selector has no effect.
module uart_rx #(
  parameter int BIT_CYC_BASE = 108,
  parameter int CNT_W        = 14
) (
  input  logic     clock,
  input  logic     resetn,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } state_t;

  logic [1:0]       sync_r;
  logic             rx_s;
  state_t           state_r;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] bit_cyc_r;
  logic [CNT_W-1:0] bit_cyc_sel_s;
  logic [CNT_W-1:0] target_s;
  logic             sample_s;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       rec_data_r;
  logic             rec_valid_r;
  logic             frame_err_r;
  logic             rx_busy_r;

  // Two-flop synchroniser for the asynchronous RX line; resets to idle-high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], bus.RX};
    end
  end

  assign rx_s = sync_r[1];

  // Bit period requested by the current selector; only latched when a frame starts.
  always_comb begin
    bit_cyc_sel_s = CNT_W'(BIT_CYC_BASE) << (3'd7 - bus.baud_rx_sel);
  end

  // Sample point: half a bit into the start bit, a full bit for data/stop.
  always_comb begin
    target_s = bit_cyc_r;
    if (state_r == ST_START) begin
      target_s = bit_cyc_r >> 1;
    end else begin
      target_s = bit_cyc_r;
    end
  end

  assign sample_s = (timer_r == (target_s - CNT_W'(1)));

  // Receive FSM with registered outputs; pulses default low every clock.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      timer_r     <= {CNT_W{1'b0}};
      bit_cyc_r   <= CNT_W'(BIT_CYC_BASE);
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      rec_data_r  <= 8'h00;
      rec_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      rx_busy_r   <= 1'b0;
    end else begin
      rec_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      if (!bus.uart_en) begin
        // Disabling drops any partial frame silently; rec_data is kept.
        state_r   <= ST_IDLE;
        timer_r   <= {CNT_W{1'b0}};
        bit_idx_r <= 3'd0;
        rx_busy_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            timer_r   <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            if (!rx_s) begin
              state_r   <= ST_START;
              bit_cyc_r <= bit_cyc_sel_s;
              rx_busy_r <= 1'b1;
            end
          end
          ST_START: begin
            if (sample_s) begin
              timer_r   <= {CNT_W{1'b0}};
              bit_idx_r <= 3'd0;
              if (rx_s) begin
                // Line went back high before mid start bit: treat as a glitch.
                state_r   <= ST_IDLE;
                rx_busy_r <= 1'b0;
              end else begin
                state_r <= ST_DATA;
              end
            end else begin
              timer_r <= timer_r + CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (sample_s) begin
              timer_r            <= {CNT_W{1'b0}};
              shift_r[bit_idx_r] <= rx_s;
              if (bit_idx_r == 3'd7) begin
                state_r <= ST_STOP;
              end else begin
                bit_idx_r <= bit_idx_r + 3'd1;
              end
            end else begin
              timer_r <= timer_r + CNT_W'(1);
            end
          end
          ST_STOP: begin
            if (sample_s) begin
              timer_r <= {CNT_W{1'b0}};
              if (rx_s) begin
                rec_data_r  <= shift_r;
                rec_valid_r <= 1'b1;
                state_r     <= ST_IDLE;
                rx_busy_r   <= 1'b0;
              end else begin
                frame_err_r <= 1'b1;
                state_r     <= ST_BRK;
              end
            end else begin
              timer_r <= timer_r + CNT_W'(1);
            end
          end
          ST_BRK: begin
            // Stay here while the line is held low (break) so it is not
            // mistaken for a new start bit.
            timer_r <= {CNT_W{1'b0}};
            if (rx_s) begin
              state_r   <= ST_IDLE;
              rx_busy_r <= 1'b0;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            timer_r   <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            rx_busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rec_valid = rec_valid_r;
  assign bus.rec_data  = rec_data_r;
  assign bus.frame_err = frame_err_r;
  assign bus.rx_busy   = rx_busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx. A frame-level model queues the
// expected pulse (kind, byte, due cycle = RX fall + 9.5 bits + 3, +/-2) and
// one compare process checks every clock against it and against the last
// good byte; literal checks after each scenario pin the model.
module tb_uart_rx;
  localparam int BASE = 108;

  logic clock = 1'b0;
  logic resetn;
  uart_rx_if bus();

  uart_rx #(.BIT_CYC_BASE(BASE), .CNT_W(14)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  logic [7:0] exp_data = 8'h00;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         due;
  } ev_t;
  ev_t exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Per-cycle comparison against the frame model.
  always @(negedge clock) begin
    ev_t ev;
    if (resetn !== 1'b1) begin
      exp_data = 8'h00;
    end else begin
      check("pulse_exclusive", 32'(bus.rec_valid & bus.frame_err), 32'd0);
      if (bus.rec_valid === 1'b1) n_valid++;
      if (bus.frame_err === 1'b1) n_ferr++;
      if (bus.rec_valid === 1'b1 || bus.frame_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({bus.rec_valid, bus.frame_err}), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind_ferr", 32'(bus.frame_err), 32'(ev.ferr));
          n_tests++;
          if (cyc < ev.due - 2 || cyc > ev.due + 2) begin
            n_fail++;
            $display("FAIL pulse_time: cycle %0d, required %0d +/-2", cyc, ev.due);
          end
          if (!ev.ferr) begin
            check("rec_data_at_valid", 32'(bus.rec_data), 32'(ev.data));
            check("busy_at_valid", 32'(bus.rx_busy), 32'd0);
            exp_data = ev.data;
          end else begin
            check("busy_at_ferr", 32'(bus.rx_busy), 32'd1);
          end
        end
      end
      check("rec_data_hold", 32'(bus.rec_data), 32'(exp_data));
      if (exp_q.size() > 0 && cyc > exp_q[0].due + 2) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_pulse: none by cycle %0d, required near %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(logic v, int bc);
    bus.RX = v;
    wait_cyc(bc);
  endtask

  // Whole 8N1 frame, LSB first; stop bit value chooses good frame or framing error.
  task automatic send_frame(logic [7:0] d, logic stop, int bc);
    ev_t ev;
    ev.ferr = ~stop;
    ev.data = d;
    ev.due  = cyc + (19 * bc) / 2 + 3;
    exp_q.push_back(ev);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    drive_bit(stop, bc);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 5000) begin
      wait_cyc(1);
      k++;
    end
    n_tests++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    bus.uart_en     = 1'b0;
    bus.baud_rx_sel = 3'd7;
    bus.RX          = 1'b1;
    resetn          = 1'b0;
    wait_cyc(3);
    check("rst_rec_valid", 32'(bus.rec_valid), 32'd0);
    check("rst_rec_data",  32'(bus.rec_data),  32'h00);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_rx_busy",   32'(bus.rx_busy),   32'd0);
    resetn = 1'b1;
    bus.uart_en = 1'b1;
    wait_cyc(5);

    // T1: 0x5A at 108 clocks/bit
    send_frame(8'h5A, 1'b1, 108);
    wait_cyc(20);
    drain();
    check("t1_data", 32'(bus.rec_data), 32'h5A);
    check("t1_nvalid", 32'(n_valid), 32'd1);
    check("t1_nferr", 32'(n_ferr), 32'd0);

    // T2: back-to-back 0xA5, 0x3C at 216 clocks/bit
    bus.baud_rx_sel = 3'd6;
    send_frame(8'hA5, 1'b1, 216);
    send_frame(8'h3C, 1'b1, 216);
    wait_cyc(20);
    drain();
    check("t2_data", 32'(bus.rec_data), 32'h3C);
    check("t2_nvalid", 32'(n_valid), 32'd3);

    // T3: 30-clock glitch, then 0x81
    bus.baud_rx_sel = 3'd7;
    bus.RX = 1'b0;
    wait_cyc(30);
    bus.RX = 1'b1;
    wait_cyc(60);
    check("t3_busy_after_glitch", 32'(bus.rx_busy), 32'd0);
    check("t3_no_pulse", 32'(n_valid + n_ferr), 32'd3);
    send_frame(8'h81, 1'b1, 108);
    wait_cyc(20);
    drain();
    check("t3_data", 32'(bus.rec_data), 32'h81);
    check("t3_nvalid", 32'(n_valid), 32'd4);

    // T4: stop bit low, line held low 500 more clocks
    send_frame(8'h5A, 1'b0, 108);
    wait_cyc(500);
    check("t4_busy_in_break", 32'(bus.rx_busy), 32'd1);
    check("t4_nferr", 32'(n_ferr), 32'd1);
    check("t4_data_kept", 32'(bus.rec_data), 32'h81);
    bus.RX = 1'b1;
    wait_cyc(5);
    check("t4_busy_released", 32'(bus.rx_busy), 32'd0);

    // T5: disable during data bit 3, then 0xFF
    drive_bit(1'b0, 108);
    drive_bit(1'b1, 108);
    drive_bit(1'b0, 108);
    drive_bit(1'b1, 108);
    drive_bit(1'b1, 54);
    check("t5_busy_mid_frame", 32'(bus.rx_busy), 32'd1);
    bus.uart_en = 1'b0;
    wait_cyc(1);
    check("t5_busy_after_disable", 32'(bus.rx_busy), 32'd0);
    bus.RX = 1'b1;
    wait_cyc(200);
    check("t5_no_pulse", 32'(n_valid + n_ferr), 32'd5);
    bus.uart_en = 1'b1;
    wait_cyc(5);
    send_frame(8'hFF, 1'b1, 108);
    wait_cyc(20);
    drain();
    check("t5_data", 32'(bus.rec_data), 32'hFF);
    check("t5_nvalid", 32'(n_valid), 32'd5);

    // T6: reset mid-frame for 3 clocks
    drive_bit(1'b0, 108);
    drive_bit(1'b1, 108);
    drive_bit(1'b0, 50);
    resetn = 1'b0;
    bus.RX = 1'b1;
    #1;
    check("t6_rst_rec_valid", 32'(bus.rec_valid), 32'd0);
    check("t6_rst_rec_data",  32'(bus.rec_data),  32'h00);
    check("t6_rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("t6_rst_rx_busy",   32'(bus.rx_busy),   32'd0);
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(2000);
    check("t6_busy_idle", 32'(bus.rx_busy), 32'd0);
    check("t6_no_pulse", 32'(n_valid + n_ferr), 32'd6);
    check("t6_data_reset", 32'(bus.rec_data), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
